// File: rtl/gshare_btb_if.sv
// Fetch-side lookup and resolved-branch update signals of the gshare/BTB predictor.
// The predictor takes the slave side and the fetch/resolve logic takes the master side.
interface gshare_btb_if #(
  parameter int ADDR_W = 32,
  parameter int HIST_W = 6
);
  logic              rdy_in;
  logic [ADDR_W-1:0] pc_in;
  logic              fire_in;
  logic [ADDR_W-1:0] next_pc_out;
  logic              taken_out;
  logic              hit_out;
  logic [HIST_W-1:0] hist_out;
  logic              write_enable;
  logic [ADDR_W-1:0] write_pc;
  logic [ADDR_W-1:0] write_target;
  logic              write_taken;
  logic [HIST_W-1:0] write_hist;
  logic              write_mispredict;

  modport slave (
    input  rdy_in, pc_in, fire_in,
    input  write_enable, write_pc, write_target, write_taken, write_hist, write_mispredict,
    output next_pc_out, taken_out, hit_out, hist_out
  );

  modport master (
    output rdy_in, pc_in, fire_in,
    output write_enable, write_pc, write_target, write_taken, write_hist, write_mispredict,
    input  next_pc_out, taken_out, hit_out, hist_out
  );
endinterface

// File: rtl/gshare_btb_predictor.sv
// Direct-mapped BTB plus gshare pattern table with a speculative global history register.
// Lookup is combinational; training, history shift and mispredict recovery happen on the clock edge.
module gshare_btb_predictor #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 8,
  parameter int CNT_W  = 2,
  parameter int HIST_W = 6
) (
  input  logic            clk_in,
  input  logic            rstn_in,
  gshare_btb_if.slave     bus
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Widening by one bit keeps the shift legal when the history is a single bit.
  function automatic logic [HIST_W-1:0] shift_hist(input logic [HIST_W-1:0] hist,
                                                    input logic            bit_in);
    logic [HIST_W:0] ext;
    ext = {hist, bit_in};
    return ext[HIST_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_update(input logic [CNT_W-1:0] cnt,
                                                  input logic            up);
    logic [CNT_W-1:0] res;
    if (up) begin
      res = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    end else begin
      res = (cnt == CNT_ZERO) ? cnt : cnt - CNT_W'(1);
    end
    return res;
  endfunction

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];
  logic [CNT_W-1:0]   pht_q    [ENTRIES];
  logic [CNT_W-1:0]   pht_d    [ENTRIES];
  logic [HIST_W-1:0]  ghr_q, ghr_d;

  logic [IDX_W-1:0]   rd_idx_s, rd_pht_idx_s, wr_idx_s, wr_pht_idx_s;
  logic [TAG_W-1:0]   rd_tag_s, wr_tag_s;
  logic               hit_s, taken_s;

  assign rd_idx_s     = bus.pc_in[IDX_W+1:2];
  assign rd_tag_s     = bus.pc_in[IDX_W+TAG_W+1:IDX_W+2];
  assign rd_pht_idx_s = rd_idx_s ^ IDX_W'(ghr_q);
  assign wr_idx_s     = bus.write_pc[IDX_W+1:2];
  assign wr_tag_s     = bus.write_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign wr_pht_idx_s = wr_idx_s ^ IDX_W'(bus.write_hist);

  // Lookup reads only registered state, so a same-cycle update shows up one cycle later.
  assign hit_s   = valid_q[rd_idx_s] && (tag_q[rd_idx_s] == rd_tag_s);
  assign taken_s = hit_s && pht_q[rd_pht_idx_s][CNT_W-1];

  assign bus.hit_out     = hit_s;
  assign bus.taken_out   = taken_s;
  assign bus.next_pc_out = taken_s ? target_q[rd_idx_s] : bus.pc_in + ADDR_W'(4);
  assign bus.hist_out    = ghr_q;

  // Next-state for BTB, PHT and GHR; rdy_in low holds everything.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    pht_d    = pht_q;
    ghr_d    = ghr_q;
    if (bus.rdy_in) begin
      if (bus.write_enable) begin
        valid_d[wr_idx_s]  = 1'b1;
        tag_d[wr_idx_s]    = wr_tag_s;
        target_d[wr_idx_s] = bus.write_target;
        pht_d[wr_pht_idx_s] = sat_update(pht_q[wr_pht_idx_s], bus.write_taken);
      end else begin
        valid_d = valid_q;
      end
      // Recovery rebuilds history from the branch's own fetch-time snapshot.
      if (bus.write_enable && bus.write_mispredict) begin
        ghr_d = shift_hist(bus.write_hist, bus.write_taken);
      end else if (bus.fire_in && hit_s) begin
        ghr_d = shift_hist(ghr_q, taken_s);
      end else begin
        ghr_d = ghr_q;
      end
    end else begin
      ghr_d = ghr_q;
    end
  end

  // Valid bits, counters and history clear asynchronously.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      valid_q <= '0;
      ghr_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= CNT_INIT;
      end
    end else begin
      valid_q <= valid_d;
      ghr_q   <= ghr_d;
      pht_q   <= pht_d;
    end
  end

  // Tag and target storage carries no reset; valid bits gate their use.
  always_ff @(posedge clk_in) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Table-driven bench for gshare_btb_predictor with a scoreboard queue of expected lookups,
// plus hand sequences for mispredict recovery and asynchronous reset.
module tb_gshare_btb_predictor;

  logic clk_in = 1'b0;
  logic rstn_in;
  always #5 clk_in = ~clk_in;

  gshare_btb_if #(.ADDR_W(32), .HIST_W(6)) bus ();

  gshare_btb_predictor #(
    .ADDR_W(32), .IDX_W(6), .TAG_W(8), .CNT_W(2), .HIST_W(6)
  ) dut (
    .clk_in (clk_in),
    .rstn_in(rstn_in),
    .bus    (bus)
  );

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] next;
    logic [5:0]  hist;
    string       name;
  } exp_t;

  typedef struct {
    string       name;
    logic        rdy, we;
    logic [31:0] wpc, wtgt;
    logic        wtaken;
    logic [5:0]  whist;
    logic        wmisp, fire;
    logic [31:0] pc;
    logic        hit, taken;
    logic [31:0] next;
    logic [5:0]  hist;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   tests = 0;
  int   failed = 0;

  function automatic vec_t mk(string name, logic rdy, logic we, logic [31:0] wpc,
                              logic [31:0] wtgt, logic wtaken, logic [5:0] whist,
                              logic wmisp, logic fire, logic [31:0] pc, logic hit,
                              logic taken, logic [31:0] next, logic [5:0] hist);
    vec_t v;
    v.name = name; v.rdy = rdy; v.we = we; v.wpc = wpc; v.wtgt = wtgt;
    v.wtaken = wtaken; v.whist = whist; v.wmisp = wmisp; v.fire = fire; v.pc = pc;
    v.hit = hit; v.taken = taken; v.next = next; v.hist = hist;
    return v;
  endfunction

  task automatic drive(input logic rdy, input logic we, input logic [31:0] wpc,
                       input logic [31:0] wtgt, input logic wtaken, input logic [5:0] whist,
                       input logic wmisp, input logic fire, input logic [31:0] pc);
    bus.rdy_in = rdy; bus.write_enable = we; bus.write_pc = wpc;
    bus.write_target = wtgt; bus.write_taken = wtaken; bus.write_hist = whist;
    bus.write_mispredict = wmisp; bus.fire_in = fire; bus.pc_in = pc;
  endtask

  task automatic drive_idle(input logic [31:0] pc);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b0, pc);
  endtask

  task automatic expect_out(input string name, input logic hit, input logic taken,
                            input logic [31:0] next, input logic [5:0] hist);
    exp_t e;
    e.name = name; e.hit = hit; e.taken = taken; e.next = next; e.hist = hist;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    tests++;
    if (sb_q.size() == 0) begin
      failed++;
      $display("FAIL scoreboard_empty: no expected entry queued");
    end else begin
      e = sb_q.pop_front();
      if (bus.hit_out !== e.hit || bus.taken_out !== e.taken ||
          bus.next_pc_out !== e.next || bus.hist_out !== e.hist) begin
        failed++;
        $display("FAIL %s: got hit=%b taken=%b next=%h hist=%h, want hit=%b taken=%b next=%h hist=%h",
                 e.name, bus.hit_out, bus.taken_out, bus.next_pc_out, bus.hist_out,
                 e.hit, e.taken, e.next, e.hist);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  initial begin
    drive_idle(32'h0000_1000);
    rstn_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rstn_in = 1'b1;

    vecs.push_back(mk("reset_lookup", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0000_1000, 1'b0, 1'b0, 32'h0000_1004, 6'h00));
    vecs.push_back(mk("wr_same_cycle", 1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b1, 6'h00, 1'b0, 1'b0, 32'h0000_1000, 1'b0, 1'b0, 32'h0000_1004, 6'h00));
    vecs.push_back(mk("trained_hit", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000, 6'h00));
    vecs.push_back(mk("tag_miss", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0000_1100, 1'b0, 1'b0, 32'h0000_1104, 6'h00));
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk("sat_wr", 1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b1, 6'h00, 1'b0, 1'b0, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000, 6'h00));
    end
    vecs.push_back(mk("nt_wr1", 1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000, 6'h00));
    vecs.push_back(mk("cnt2_taken", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000, 6'h00));
    vecs.push_back(mk("nt_wr2", 1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000, 6'h00));
    vecs.push_back(mk("cnt1_not_taken", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0000_1000, 1'b1, 1'b0, 32'h0000_1004, 6'h00));
    vecs.push_back(mk("rdy0_write", 1'b0, 1'b1, 32'h0000_1040, 32'h0000_3000, 1'b1, 6'h3F, 1'b1, 1'b1, 32'h0000_1040, 1'b0, 1'b0, 32'h0000_1044, 6'h00));
    vecs.push_back(mk("rdy0_btb_kept", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0000_1040, 1'b0, 1'b0, 32'h0000_1044, 6'h00));
    vecs.push_back(mk("rdy0_ghr_kept", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0000_1000, 1'b1, 1'b0, 32'h0000_1004, 6'h00));
    vecs.push_back(mk("misp_no_we", 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 6'h3F, 1'b1, 1'b0, 32'h0000_1000, 1'b1, 1'b0, 32'h0000_1004, 6'h00));
    vecs.push_back(mk("misp_ignored", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0000_1000, 1'b1, 1'b0, 32'h0000_1004, 6'h00));
    vecs.push_back(mk("fire_on_miss", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b1, 32'h0000_1100, 1'b0, 1'b0, 32'h0000_1104, 6'h00));
    vecs.push_back(mk("miss_ghr_kept", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0000_1000, 1'b1, 1'b0, 32'h0000_1004, 6'h00));
    vecs.push_back(mk("pc_wrap", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, 6'h00));

    foreach (vecs[i]) begin
      drive(vecs[i].rdy, vecs[i].we, vecs[i].wpc, vecs[i].wtgt, vecs[i].wtaken,
            vecs[i].whist, vecs[i].wmisp, vecs[i].fire, vecs[i].pc);
      expect_out(vecs[i].name, vecs[i].hit, vecs[i].taken, vecs[i].next, vecs[i].hist);
      #2;
      check_out();
      tick();
    end

    // Mispredict recovery racing a fire_in hit in the same cycle.
    drive_idle(32'h0000_1000);
    rstn_in = 1'b0;
    #2;
    rstn_in = 1'b1;
    drive(1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b1, 6'h00, 1'b0, 1'b0, 32'h0000_1000);
    tick();
    drive(1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b1, 6'h01, 1'b0, 1'b0, 32'h0000_1000);
    tick();
    drive(1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b1, 6'h03, 1'b0, 1'b0, 32'h0000_1000);
    tick();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'h00, 1'b0, 1'b1, 32'h0000_1000);
    expect_out("fire_hist0", 1'b1, 1'b1, 32'h0000_2000, 6'h00);
    #2; check_out(); tick();
    expect_out("fire_hist1", 1'b1, 1'b1, 32'h0000_2000, 6'h01);
    #2; check_out(); tick();
    expect_out("fire_hist3", 1'b1, 1'b1, 32'h0000_2000, 6'h03);
    #2; check_out(); tick();
    drive(1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b0, 6'h05, 1'b1, 1'b1, 32'h0000_1000);
    expect_out("ghr_07_before_recover", 1'b1, 1'b0, 32'h0000_1004, 6'h07);
    #2; check_out(); tick();
    drive_idle(32'h0000_1000);
    expect_out("ghr_recovered_0a", 1'b1, 1'b0, 32'h0000_1004, 6'h0A);
    #2; check_out();

    // Reset pulsed between edges, held across an edge with a write pending.
    rstn_in = 1'b0;
    #1;
    expect_out("async_reset_now", 1'b0, 1'b0, 32'h0000_1004, 6'h00);
    check_out();
    drive(1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b1, 6'h00, 1'b1, 1'b1, 32'h0000_1000);
    tick();
    rstn_in = 1'b1;
    drive_idle(32'h0000_1000);
    expect_out("write_during_reset_dropped", 1'b0, 1'b0, 32'h0000_1004, 6'h00);
    #2; check_out();
    drive(1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b0, 6'h00, 1'b0, 1'b0, 32'h0000_1000);
    tick();
    drive(1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 1'b1, 6'h00, 1'b0, 1'b0, 32'h0000_1000);
    tick();
    drive_idle(32'h0000_1000);
    expect_out("pht_reset_weak_nt", 1'b1, 1'b0, 32'h0000_1004, 6'h00);
    #2; check_out();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/gshare_btb_predictor.md
GSHARE_BTB_PREDICTOR -- requirements
Module: gshare_btb_predictor

Interface
REQ-001 Parameter ADDR_W, default 32: PC and target width.
REQ-002 Parameter IDX_W, default 6: log2 of BTB and PHT entry count.
REQ-003 Parameter TAG_W, default 8: BTB tag width, taken from pc[IDX_W+TAG_W+1:IDX_W+2].
REQ-004 Parameter CNT_W, default 2: PHT saturating-counter width, legal 1..4.
REQ-005 Parameter HIST_W, default 6: global-history width, legal 1..IDX_W.
REQ-006 Port clk_in, input, 1: single clock; all state changes on its rising edge.
REQ-007 Port rstn_in, input, 1: reset, asynchronous, active-low.
REQ-008 Port rdy_in, input, 1: global enable; 0 freezes all state.
REQ-009 Port pc_in, input, ADDR_W: fetch PC to predict.
REQ-010 Port fire_in, input, 1: fetch accepted this cycle; advances speculative history.
REQ-011 Port next_pc_out, output, ADDR_W: predicted next PC.
REQ-012 Port taken_out, output, 1: prediction is taken.
REQ-013 Port hit_out, output, 1: BTB hit for pc_in.
REQ-014 Port hist_out, output, HIST_W: history value used for this lookup; carried down the pipe and returned as write_hist.
REQ-015 Port write_enable, input, 1: resolved-branch update strobe.
REQ-016 Port write_pc, input, ADDR_W: PC of the resolved branch.
REQ-017 Port write_target, input, ADDR_W: resolved target.
REQ-018 Port write_taken, input, 1: resolved direction.
REQ-019 Port write_hist, input, HIST_W: hist_out captured at that branch's fetch.
REQ-020 Port write_mispredict, input, 1: qualifies write_enable; triggers history recovery.

Function
REQ-021 Index = pc[IDX_W+1:2]; BTB is indexed by index alone; PHT index = index XOR zero-extended history.
REQ-022 Lookup is combinational from pc_in and current GHR: hit_out = valid[idx] AND tag match.
REQ-023 taken_out = hit_out AND PHT counter MSB; next_pc_out = target[idx] if taken_out, else pc_in+4, with wrap modulo 2^ADDR_W.
REQ-024 hist_out = current GHR.
REQ-025 fire_in=1 with hit_out=1: GHR <= {GHR[HIST_W-2:0], taken_out} (for HIST_W=1, GHR <= taken_out); fire_in on a miss leaves GHR unchanged.
REQ-026 write_enable=1: BTB[write_pc idx] gets valid=1, tag, and write_target; PHT[write_pc idx XOR write_hist] increments if write_taken, else decrements, saturating at 0 and 2^CNT_W-1.
REQ-027 write_enable=1 with write_mispredict=1: GHR <= {write_hist[HIST_W-2:0], write_taken}; this has priority over the fire_in shift in the same cycle.
REQ-028 Read and write to the same entry in one cycle: the lookup returns the pre-write value; the update is visible the next cycle.
REQ-029 rdy_in=0: no BTB, PHT, or GHR change; outputs remain the combinational function of pc_in and current state.
REQ-030 write_mispredict without write_enable is ignored.

Reset
REQ-031 rstn_in low, immediately and regardless of clock: all BTB valid bits cleared; every PHT counter set to 2^(CNT_W-1)-1 (weakly not-taken); GHR cleared to 0.
REQ-032 During reset, outputs follow the cleared state: hit_out=0, taken_out=0, next_pc_out=pc_in+4, hist_out=0.
REQ-033 BTB tag and target contents need no reset.
REQ-034 Reset asserted mid-update discards that update.

Verification (defaults)
REQ-035 After reset, pc_in=0x1000 -> hit_out=0, taken_out=0, next_pc_out=0x1004, hist_out=0.
REQ-036 One write (pc 0x1000, target 0x2000, taken=1, hist=0, mispredict=0), then pc_in=0x1000 with GHR=0 -> hit_out=1, taken_out=1, next_pc_out=0x2000.
REQ-037 Five taken writes, then one not-taken write -> still taken (counter 2); a second not-taken write -> taken_out=0, next_pc_out=0x1004, hit_out=1.
REQ-038 Trained 0x1000, lookup 0x1100 (same index, different tag) -> hit_out=0, next_pc_out=0x1104.
REQ-039 Three fire_in hits on a taken entry (GHR=0x07), then write_enable plus write_mispredict with write_hist=0x05, write_taken=0, and fire_in=1 in the same cycle -> GHR=0x0A next cycle.
REQ-040 Coverage: rdy_in=0 during write_enable leaves all state unchanged; rstn_in pulsed low between clock edges after training -> outputs return to REQ-035 values immediately.
